q6_input_conditioner: RTL and testbench

- Upstream front-end for the q6 sequential circuit; drives its E and W inputs.
- Takes raw, asynchronous, bouncy E/W sensor lines and produces clean, synchronized, debounced levels plus one-cycle rising-edge pulses.
- All outputs are registered, so the q6 circuit only ever sees changes aligned to CLK.

---
 rtl/q6_input_conditioner_pkg.sv | 13 +
 rtl/q6_input_conditioner_if.sv | 24 ++
 rtl/q6_debounce_chan.sv | 87 ++++++++
 rtl/q6_input_conditioner.sv | 31 +++
 tb/tb_q6_input_conditioner.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/q6_input_conditioner_pkg.sv
// Shared types and constants for the q6 input conditioner.
// Optional glitch counters are enabled by defining Q6_COND_GLITCH_CNT_EN.
package q6_cond_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  localparam int                    GLITCH_CNT_W   = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'd255;

endpackage

// File: rtl/q6_input_conditioner_if.sv
// Sensor-side bundle of the q6 input conditioner: raw lines in, clean levels out.
// The glitch count signals carry zero unless Q6_COND_GLITCH_CNT_EN is defined.
import q6_cond_pkg::*;

interface q6_input_conditioner_if;
  logic                    e_raw;
  logic                    w_raw;
  logic                    e;
  logic                    w;
  logic                    e_rise;
  logic                    w_rise;
  logic [GLITCH_CNT_W-1:0] e_glitch_cnt;
  logic [GLITCH_CNT_W-1:0] w_glitch_cnt;

  modport master (
    output e_raw, w_raw,
    input  e, w, e_rise, w_rise, e_glitch_cnt, w_glitch_cnt
  );

  modport slave (
    input  e_raw, w_raw,
    output e, w, e_rise, w_rise, e_glitch_cnt, w_glitch_cnt
  );
endinterface

// File: rtl/q6_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, STABLE/PENDING FSM, rise pulse.
// Q6_COND_GLITCH_CNT_EN adds a saturating count of aborted PENDING runs.
module q6_debounce_chan
  import q6_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    raw,
  output logic                    lvl,
  output logic                    rise,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
`ifdef Q6_COND_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
`ifdef Q6_COND_GLITCH_CNT_EN
      glitch_q <= '0;
`endif
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      case (state)
        STABLE: begin
          cnt <= '0;
          if (s2 != lvl) begin
            // A single required cycle flips on the first mismatch
            if (DEBOUNCE_CYCLES == 1) begin
              lvl  <= s2;
              rise <= s2;
            end else begin
              state <= PENDING;
              cnt   <= CNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (s2 == lvl) begin
            state <= STABLE;
            cnt   <= '0;
`ifdef Q6_COND_GLITCH_CNT_EN
            if (glitch_q != GLITCH_CNT_MAX)
              glitch_q <= glitch_q + 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state <= STABLE;
            cnt   <= '0;
            lvl   <= s2;
            rise  <= s2;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef Q6_COND_GLITCH_CNT_EN
  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: rtl/q6_input_conditioner.sv
// Two independent debounce channels producing clean E/W levels for the q6 circuit.
// Glitch counters appear only when Q6_COND_GLITCH_CNT_EN is defined.
module q6_input_conditioner
  import q6_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  q6_input_conditioner_if.slave  bus
);

  q6_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_e_chan (
    .clk        (clk),
    .rst        (rst),
    .raw        (bus.e_raw),
    .lvl        (bus.e),
    .rise       (bus.e_rise),
    .glitch_cnt (bus.e_glitch_cnt)
  );

  q6_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_w_chan (
    .clk        (clk),
    .rst        (rst),
    .raw        (bus.w_raw),
    .lvl        (bus.w),
    .rise       (bus.w_rise),
    .glitch_cnt (bus.w_glitch_cnt)
  );

endmodule

// File: tb/tb_q6_input_conditioner.sv
// Directed bench for q6_input_conditioner: a default DUT plus a one-cycle DUT
// sharing its raw inputs for the fast-fall case.
module tb_q6_input_conditioner;

`ifdef Q6_COND_GLITCH_CNT_EN
  localparam int GLITCH_ON = 1;
`else
  localparam int GLITCH_ON = 0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  q6_input_conditioner_if ifm ();
  q6_input_conditioner_if if1 ();

  assign if1.e_raw = ifm.e_raw;
  assign if1.w_raw = ifm.w_raw;

  q6_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifm.slave)
  );

  q6_input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " e"}, int'(ifm.e), 0);
    chk({tag, " w"}, int'(ifm.w), 0);
    chk({tag, " e_rise"}, int'(ifm.e_rise), 0);
    chk({tag, " w_rise"}, int'(ifm.w_rise), 0);
    chk({tag, " e_gcnt"}, int'(ifm.e_glitch_cnt), 0);
    chk({tag, " w_gcnt"}, int'(ifm.w_glitch_cnt), 0);
  endtask

  initial begin
    int e_seen;
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    ifm.e_raw = 1'b0;
    ifm.w_raw = 1'b0;
    #2;
    chk_all_zero("init_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    step(3);

    // clean rising step on E: high after the 6th edge counting k as the 1st
    ifm.e_raw = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step(1);
      chk($sformatf("step e i=%0d", i), int'(ifm.e), (i >= 5) ? 1 : 0);
      chk($sformatf("step e_rise i=%0d", i), int'(ifm.e_rise), (i == 5) ? 1 : 0);
      chk($sformatf("step w i=%0d", i), int'(ifm.w), 0);
    end

    // two-cycle glitch on W is rejected
    ifm.w_raw = 1'b1;
    step(2);
    ifm.w_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("glitch w i=%0d", i), int'(ifm.w), 0);
      chk($sformatf("glitch w_rise i=%0d", i), int'(ifm.w_rise), 0);
    end
    chk("glitch w_gcnt", int'(ifm.w_glitch_cnt), GLITCH_ON ? 1 : 0);
    chk("glitch e_gcnt", int'(ifm.e_glitch_cnt), 0);

    // async reset mid-cycle with E=1 and both raw lines high
    ifm.w_raw = 1'b1;
    step(1);
    chk("pre_rst e", int'(ifm.e), 1);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    ifm.e_raw = 1'b0;
    ifm.w_raw = 1'b0;
    step(8);
    chk("post_rst e", int'(ifm.e), 0);

    // bounce 1,0,1,0,1 then hold; final 0->1 lands before edge k
    ifm.e_raw = 1'b1; step(1);
    ifm.e_raw = 1'b0; step(1);
    ifm.e_raw = 1'b1; step(1);
    ifm.e_raw = 1'b0; step(1);
    chk("bounce pre e", int'(ifm.e), 0);
    ifm.e_raw = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step(1);
      chk($sformatf("bounce e i=%0d", i), int'(ifm.e), (i >= 5) ? 1 : 0);
      chk($sformatf("bounce e_rise i=%0d", i), int'(ifm.e_rise), (i == 5) ? 1 : 0);
    end
    chk("bounce e_gcnt", int'(ifm.e_glitch_cnt), GLITCH_ON ? 2 : 0);

    // simultaneous fall on both channels
    ifm.w_raw = 1'b1;
    step(8);
    chk("fall pre w", int'(ifm.w), 1);
    chk("fall pre dut1 e", int'(if1.e), 1);
    chk("fall pre dut1 w", int'(if1.w), 1);
    ifm.e_raw = 1'b0;
    ifm.w_raw = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      step(1);
      chk($sformatf("fall e i=%0d", i), int'(ifm.e), (i < 5) ? 1 : 0);
      chk($sformatf("fall w i=%0d", i), int'(ifm.w), (i < 5) ? 1 : 0);
      chk($sformatf("fall rise i=%0d", i), int'(ifm.e_rise) + int'(ifm.w_rise), 0);
      chk($sformatf("fall dut1 e i=%0d", i), int'(if1.e), (i < 2) ? 1 : 0);
      chk($sformatf("fall dut1 w i=%0d", i), int'(if1.w), (i < 2) ? 1 : 0);
      chk($sformatf("fall dut1 rise i=%0d", i), int'(if1.e_rise) + int'(if1.w_rise), 0);
    end

    // 300 two-cycle glitches on E saturate the counter
    e_seen = 0;
    for (int g = 0; g < 300; g++) begin
      ifm.e_raw = 1'b1;
      step(2);
      ifm.e_raw = 1'b0;
      for (int j = 0; j < 3; j++) begin
        step(1);
        if (ifm.e !== 1'b0 || ifm.e_rise !== 1'b0) e_seen = 1;
      end
    end
    step(4);
    chk("sat e stayed low", e_seen, 0);
    chk("sat e_gcnt", int'(ifm.e_glitch_cnt), GLITCH_ON ? 255 : 0);
    step(10);
    chk("sat e_gcnt hold", int'(ifm.e_glitch_cnt), GLITCH_ON ? 255 : 0);
    chk("sat e", int'(ifm.e), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
